// File: rtl/td4_exec_ctrl.sv
// td4_exec_ctrl: run/halt/step/breakpoint execution controller producing a one-cycle
// clock-enable for the TD4 core, with run-mode prescaler and executed-instruction counter.
module td4_exec_ctrl #(
   parameter int DIV   = 1,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rstb,
   input  logic             i_start,
   input  logic             i_step,
   input  logic             i_stop,
   input  logic             i_clr,
   input  logic             i_brk_en,
   input  logic [3:0]       i_brk_addr,
   input  logic [3:0]       i_pc,
   output logic             o_ce,
   output logic             o_running,
   output logic             o_brk_hit,
   output logic [CNT_W-1:0] o_icount
);
   localparam logic [1:0] S_HALT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_STEP = 2'd2;
   localparam logic [1:0] S_BRK  = 2'd3;
   localparam logic [7:0] PRE_MAX = 8'(DIV - 1);
   localparam logic [CNT_W-1:0] ONE = 1;

   logic [1:0]       r_state;
   logic [7:0]       r_pre;
   logic             r_skip;
   logic             r_start_q;
   logic             r_step_q;
   logic             r_stop_q;
   logic [CNT_W-1:0] r_icount;
   logic [1:0]       w_nxt;
   logic             w_ce;
   logic             w_start_e;
   logic             w_step_e;
   logic             w_stop_e;
   logic             w_slot;
   logic             w_match;

   assign w_start_e = i_start & ~r_start_q;
   assign w_step_e  = i_step & ~r_step_q;
   assign w_stop_e  = i_stop & ~r_stop_q;
   assign w_slot    = r_pre == PRE_MAX;
   assign w_match   = i_brk_en && (i_pc == i_brk_addr) && !r_skip;

   always_comb begin
      w_nxt = r_state;
      w_ce  = 1'b0;
      case (r_state)
         S_HALT: w_nxt = w_step_e ? S_STEP : w_start_e ? S_RUN : S_HALT;
         S_STEP: begin
            w_ce  = 1'b1;
            w_nxt = S_HALT;
         end
         S_RUN: begin
            w_nxt = w_stop_e ? S_HALT : (w_slot && w_match) ? S_BRK : S_RUN;
            w_ce  = !w_stop_e && w_slot && !w_match;
         end
         default: w_nxt = w_stop_e ? S_HALT : w_step_e ? S_STEP : w_start_e ? S_RUN : S_BRK;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         r_state   <= S_HALT;
         r_pre     <= 8'd0;
         r_skip    <= 1'b0;
         r_start_q <= 1'b1;
         r_step_q  <= 1'b1;
         r_stop_q  <= 1'b1;
         r_icount  <= '0;
      end else begin
         r_state   <= w_nxt;
         r_start_q <= i_start;
         r_step_q  <= i_step;
         r_stop_q  <= i_stop;
         // prescaler restarts from zero on every entry into RUN
         r_pre     <= (r_state == S_RUN && w_nxt == S_RUN) ? (w_slot ? 8'd0 : r_pre + 8'd1) : 8'd0;
         r_skip    <= (r_state == S_BRK && w_nxt == S_RUN) ? 1'b1 :
                      (w_nxt != S_RUN || w_ce) ? 1'b0 : r_skip;
         r_icount  <= i_clr ? '0 : w_ce ? r_icount + ONE : r_icount;
      end
   end

   assign o_ce      = w_ce;
   assign o_running = r_state == S_RUN;
   assign o_brk_hit = r_state == S_BRK;
   assign o_icount  = r_icount;
endmodule

// File: doc/td4_exec_ctrl.md
# td4_exec_ctrl

Execution controller for the 4-bit TD4 CPU. Gates CPU instruction execution through a one-cycle clock-enable and provides run, halt, single-step, a PC breakpoint, a run-mode speed prescaler and an executed-instruction counter. Sits between front-panel/testbench controls and the `td4` core; the core advances exactly one instruction on each CLK rising edge where CE=1.

## Interface

- DIV, default 1: run-mode prescaler, CE at most once every DIV cycles; legal 1..255.
- CNT_W, default 8: width of the executed-instruction counter.

- CLK  in  1  system clock, rising edge.
- RSTB  in  1  asynchronous active-low reset.
- START  in  1  level; rising edge requests run.
- STEP  in  1  level; rising edge requests one instruction.
- STOP  in  1  level; rising edge requests halt.
- CLR  in  1  synchronous clear of ICOUNT, level-sensitive.
- BRK_EN  in  1  breakpoint enable.
- BRK_ADDR  in  4  breakpoint address.
- PC  in  4  current CPU program counter (address of next instruction).
- CE  out  1  CPU clock-enable, one instruction per high cycle.
- RUNNING  out  1  high in RUN state.
- BRK_HIT  out  1  high in BREAK state.
- ICOUNT  out  CNT_W  count of CE-high cycles, wraps modulo 2^CNT_W.

## Operation

- Edge detect: each of START/STEP/STOP is registered once (x_q). Edge = x & ~x_q, evaluated in the first cycle x is high. x_q resets to 1, so a level already high at reset release does not trigger.
- Priority on simultaneous edges: STOP > STEP > START.
- States: HALT, RUN, STEP1, BREAK. Reset state HALT.
- HALT: CE=0. STEP edge -> STEP1. START edge -> RUN. STOP edge: no effect.
- STEP1: lasts exactly one cycle, CE=1 unconditionally (no breakpoint check), then -> HALT. Edges in this cycle are ignored.
- RUN: prescaler pre counts 0..DIV-1, wrapping; a slot occurs when pre==DIV-1.
  - At a slot: if BRK_EN && PC==BRK_ADDR && !skip -> CE=0, next BREAK. Otherwise CE=1, skip cleared.
  - STOP edge in any RUN cycle -> CE=0 that cycle, next HALT.
  - STEP/START edges in RUN are ignored.
- BREAK: CE=0. START edge -> RUN with skip=1, so the first slot executes even if PC still matches. STEP edge -> STEP1. STOP edge -> HALT.
- pre resets to 0 whenever RUN is entered.
- skip is set only on BREAK->RUN. It is cleared on the first CE, or on any exit from RUN.
- ICOUNT increments on every CE=1 cycle, wrapping modulo 2^CNT_W. CLR=1 forces 0 next cycle and takes precedence over a coincident CE.
- Outputs: RUNNING = (state==RUN), BRK_HIT = (state==BREAK). Both are decoded from registered state.
- CE is combinational from the state, pre, skip, edge-detect registers and the current PC/BRK/START/STEP/STOP inputs. PC must come from CPU registers. No path from CE back to PC.

## Timing

- Reset (RSTB=0, async): state=HALT, pre=0, skip=0, ICOUNT=0, x_q=1. CE=0, RUNNING=0, BRK_HIT=0 immediately.
- START edge in cycle t (from HALT): RUNNING=1 from t+1. First CE at cycle t+DIV. Steady state: one CE every DIV cycles.
- STEP edge in cycle t (from HALT or BREAK): CE=1 in cycle t+1 only, state HALT at t+2.
- Breakpoint match at slot cycle s: CE=0 at s, BRK_HIT=1 from s+1.
- STOP edge at cycle t: CE=0 at t, RUNNING=0 from t+1.
- ICOUNT reflects a CE at cycle t from cycle t+1.
- Async reset mid-run drops CE the same instant. After release, the block stays in HALT until a fresh edge.

## Test plan

- Reset then START pulse, DIV=1, BRK_EN=0, PC wrapping 0..15: CE high every cycle from t+1. After 20 cycles ICOUNT=20, RUNNING=1.
- DIV=4, START at t: CE only at t+4, t+8, t+12. STOP at t+10 -> no CE at t+12, RUNNING=0 at t+11, ICOUNT=2.
- BRK_EN=1, BRK_ADDR=5, run with PC incrementing per CE: halts with PC=5, ICOUNT=5, BRK_HIT=1. START -> CE executes at PC=5 (skip), runs on and breaks again at the next PC=5.
- From HALT, STEP held high 10 cycles: exactly one CE, ICOUNT+1, state HALT. Release and re-press -> one more CE.
- Same-cycle START+STOP edges from RUN -> HALT. Same-cycle STEP+START from HALT -> STEP1, one CE, then HALT.
- CNT_W=4: 16 CEs -> ICOUNT wraps to 0. CLR asserted coincident with a CE -> ICOUNT=0. RSTB pulsed low mid-run -> CE=0 immediately, ICOUNT=0, no restart with START held high.
